// File: rtl/argmax_stream_ctrl_bf16.sv
// Streaming bf16 argmax over NUM_CLASSES scores using one shared comparator.
// Define ARGMAX_NAN_FLAG_EN to add the nan_seen output.
module argmax_stream_ctrl_bf16 #(
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] prediction,
  output logic [15:0]      max_value,
  output logic             busy
`ifdef ARGMAX_NAN_FLAG_EN
  ,
  output logic             nan_seen
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, run_idx, cand_idx;
  logic [15:0]      run_max, cand_max;
  logic             beat, last_beat, in_nan, run_nan, take;

  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:7] == 8'hFF) && (v[6:0] != 7'd0);
  endfunction

  // Sign-magnitude mapped onto two's complement; both zeros map to 0 and tie.
  function automatic logic signed [15:0] order_key(input logic [15:0] v);
    logic signed [15:0] mag;
    mag = $signed({1'b0, v[14:0]});
    return v[15] ? -mag : mag;
  endfunction

  assign beat      = in_valid && (state == ACCUM) && !abort;
  assign last_beat = beat && (cnt == LAST_IDX);
  assign in_nan    = is_nan(in_data);
  assign run_nan   = is_nan(run_max);
  assign take      = (cnt == '0) ||
                     (!in_nan && (run_nan || (order_key(in_data) > order_key(run_max))));
  assign cand_max  = take ? in_data : run_max;
  assign cand_idx  = take ? cnt : run_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort)          state_nxt = IDLE;
        else if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (abort || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      run_idx    <= '0;
      run_max    <= '0;
      prediction <= '1;
      max_value  <= '0;
    end else if ((state != IDLE) && abort) begin
      cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cnt <= '0;
    end else if (beat) begin
      cnt     <= cnt + IDX_W'(1);
      run_idx <= cand_idx;
      run_max <= cand_max;
      // The result register takes the candidate including the final beat.
      if (last_beat) begin
        prediction <= cand_idx;
        max_value  <= cand_max;
      end
    end
  end

`ifdef ARGMAX_NAN_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      nan_seen <= 1'b0;
    end else if ((state == IDLE) && start) begin
      nan_seen <= 1'b0;
    end else if (beat && in_nan) begin
      nan_seen <= 1'b1;
    end
  end
`endif

endmodule
